// File: rtl/seq_detector_pkg.sv
// Shared definitions for the parametrised sequence detector.
//   clog2      : ceiling log2, used for index and prefix-length widths
//   st_width   : width of a prefix length that spans 0..depth
//   DEF_*      : default geometry of the detector
//   sym_t      : symbol type at the default symbol width
package seq_detector_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int st_width(input int depth);
      return clog2(depth + 1);
   endfunction

   localparam int DEF_SYM_W   = 2;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_ST_W    = st_width(DEF_DEPTH);
   localparam int DEF_CNT_MAX = (1 << DEF_CNT_W) - 1;

   typedef logic [DEF_SYM_W-1:0] sym_t;

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational prefix search for the sequence detector.
// Finds the longest pattern prefix that ends with the incoming symbol. The
// prefix may be at most one symbol longer than the current matched length.
//   pattern : DEPTH symbols, symbol 0 in the LSBs
//   hist    : previously accepted symbols, slot 0 (LSBs) is the most recent
//   sym     : incoming symbol
//   state   : current matched-prefix length
//   next_k  : next matched-prefix length
//   match   : next_k equals DEPTH
module seq_prefix_match
   import seq_detector_pkg::*;
#(
   parameter int SYM_W = DEF_SYM_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic [DEPTH*SYM_W-1:0]     pattern,
   input  logic [(DEPTH-1)*SYM_W-1:0] hist,
   input  logic [SYM_W-1:0]           sym,
   input  logic [st_width(DEPTH)-1:0] state,
   output logic [st_width(DEPTH)-1:0] next_k,
   output logic                       match
);

   localparam int ST_W = st_width(DEPTH);

   // hit[k-1]: the last k symbols (sym plus k-1 history slots) equal pattern[0..k-1]
   logic [DEPTH-1:0] hit;

   for (genvar gk = 1; gk <= DEPTH; gk++) begin : g_k
      logic [gk-1:0] eq;
      assign eq[gk-1] = (pattern[(gk-1)*SYM_W +: SYM_W] == sym);
      for (genvar gi = 0; gi < gk - 1; gi++) begin : g_i
         assign eq[gi] = (pattern[gi*SYM_W +: SYM_W] == hist[(gk-2-gi)*SYM_W +: SYM_W]);
      end
      assign hit[gk-1] = &eq;
   end

   // Limiting k to state+1 keeps the search inside history that is still valid.
   always_comb begin
      next_k = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (hit[k-1] && (k <= int'(state) + 1)) begin
            next_k = ST_W'(k);
         end
      end
   end

   assign match = (next_k == ST_W'(DEPTH));

endmodule

// File: rtl/seq_detector_param.sv
// Sequence detector over a stream of SYM_W-bit symbols with a runtime
// programmable pattern of DEPTH symbols.
//   clk         : system clock, rising edge
//   init        : asynchronous active-low reset
//   in_valid    : symbol on in is accepted this cycle
//   in          : input symbol
//   overlap     : 1 = overlapping matches, 0 = restart after a match
//   cfg_we      : pattern write strobe
//   cfg_idx     : pattern position to write
//   cfg_sym     : symbol value written
//   cnt_clr     : synchronous clear of match_count
//   out         : one-cycle match pulse
//   state       : current matched-prefix length, 0..DEPTH
//   match_count : saturating match count
module seq_detector_param
   import seq_detector_pkg::*;
#(
   parameter int                           SYM_W    = DEF_SYM_W,
   parameter int                           DEPTH    = DEF_DEPTH,
   parameter int                           CNT_W    = DEF_CNT_W,
   parameter logic [DEPTH*SYM_W-1:0]       PAT_INIT = {2'd0, 2'd2, 2'd0, 2'd1}
) (
   input  logic                        clk,
   input  logic                        init,
   input  logic                        in_valid,
   input  logic [SYM_W-1:0]            in,
   input  logic                        overlap,
   input  logic                        cfg_we,
   input  logic [clog2(DEPTH)-1:0]     cfg_idx,
   input  logic [SYM_W-1:0]            cfg_sym,
   input  logic                        cnt_clr,
   output logic                        out,
   output logic [st_width(DEPTH)-1:0]  state,
   output logic [CNT_W-1:0]            match_count
);

   localparam int ST_W = st_width(DEPTH);
   // The incoming symbol plus DEPTH-1 stored ones make up the last DEPTH symbols.
   localparam int HW   = (DEPTH - 1) * SYM_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DEPTH*SYM_W-1:0] pat_q;
   logic [HW-1:0]          hist_q;
   logic [HW-1:0]          hist_nxt;
   logic [ST_W-1:0]        state_q;
   logic [ST_W-1:0]        next_k;
   logic                   match;
   logic                   out_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   cfg_hit;
   logic                   accept;

   seq_prefix_match #(
      .SYM_W (SYM_W),
      .DEPTH (DEPTH)
   ) u_match (
      .pattern (pat_q),
      .hist    (hist_q),
      .sym     (in),
      .state   (state_q),
      .next_k  (next_k),
      .match   (match)
   );

   assign hist_nxt = HW'({hist_q, in});
   assign cfg_hit  = cfg_we && (int'(cfg_idx) < DEPTH);
   // A valid pattern write steals the cycle; the presented symbol is dropped.
   assign accept   = in_valid && !cfg_hit;

   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         pat_q   <= PAT_INIT;
         hist_q  <= '0;
         state_q <= '0;
         out_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         out_q <= 1'b0;

         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (accept && match && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
         end

         if (cfg_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (int'(cfg_idx) == i) begin
                  pat_q[i*SYM_W +: SYM_W] <= cfg_sym;
               end
            end
            state_q <= '0;
            hist_q  <= '0;
         end else if (accept) begin
            if (match) begin
               out_q <= 1'b1;
            end
            if (match && !overlap) begin
               state_q <= '0;
               hist_q  <= '0;
            end else begin
               state_q <= next_k;
               hist_q  <= hist_nxt;
            end
         end
         // Idle cycles keep the partial match; only the pulse drops.
      end
   end

   assign out         = out_q;
   assign state       = state_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

   logic       clk;
   logic       init;

   // main instance: DEPTH=4, pattern 1,0,2,0, 2-bit counter
   logic       in_valid;
   logic [1:0] in_sym;
   logic       overlap;
   logic       cfg_we;
   logic [1:0] cfg_idx;
   logic [1:0] cfg_sym;
   logic       cnt_clr;
   logic       out_a;
   logic [2:0] state_a;
   logic [1:0] cnt_a;

   // second instance: DEPTH=3, pattern 1,0,2, to reach an out-of-range cfg_idx
   logic       in_valid_b;
   logic [1:0] in_sym_b;
   logic       cfg_we_b;
   logic [1:0] cfg_idx_b;
   logic [1:0] cfg_sym_b;
   logic       out_b;
   logic [1:0] state_b;
   logic [3:0] cnt_b;

   int n_chk;
   int n_fail;

   int sq_ovl [6] = '{1, 0, 1, 0, 1, 0};
   int st_ovl [6] = '{1, 2, 3, 4, 3, 4};
   int ot_ovl [6] = '{0, 0, 0, 1, 0, 1};
   int st_nov [6] = '{1, 2, 3, 0, 1, 2};
   int ot_nov [6] = '{0, 0, 0, 1, 0, 0};
   int sq_def [4] = '{1, 0, 2, 0};
   int cnt_sat[5] = '{1, 2, 3, 3, 3};

   seq_detector_param #(
      .SYM_W    (2),
      .DEPTH    (4),
      .CNT_W    (2),
      .PAT_INIT ({2'd0, 2'd2, 2'd0, 2'd1})
   ) dut (
      .clk         (clk),
      .init        (init),
      .in_valid    (in_valid),
      .in          (in_sym),
      .overlap     (overlap),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_sym     (cfg_sym),
      .cnt_clr     (cnt_clr),
      .out         (out_a),
      .state       (state_a),
      .match_count (cnt_a)
   );

   seq_detector_param #(
      .SYM_W    (2),
      .DEPTH    (3),
      .CNT_W    (4),
      .PAT_INIT ({2'd2, 2'd0, 2'd1})
   ) dut_b (
      .clk         (clk),
      .init        (init),
      .in_valid    (in_valid_b),
      .in          (in_sym_b),
      .overlap     (1'b0),
      .cfg_we      (cfg_we_b),
      .cfg_idx     (cfg_idx_b),
      .cfg_sym     (cfg_sym_b),
      .cnt_clr     (1'b0),
      .out         (out_b),
      .state       (state_b),
      .match_count (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      init       = 1'b0;
      in_valid   = 1'b0;
      in_sym     = 2'd0;
      cfg_we     = 1'b0;
      cfg_idx    = 2'd0;
      cfg_sym    = 2'd0;
      cnt_clr    = 1'b0;
      in_valid_b = 1'b0;
      in_sym_b   = 2'd0;
      cfg_we_b   = 1'b0;
      cfg_idx_b  = 2'd0;
      cfg_sym_b  = 2'd0;
      @(negedge clk);
      init = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int s);
      in_valid = 1'b1;
      in_sym   = 2'(s);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_b(input int s);
      in_valid_b = 1'b1;
      in_sym_b   = 2'(s);
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input int idx, input int s);
      in_valid = 1'b0;
      cfg_we   = 1'b1;
      cfg_idx  = 2'(idx);
      cfg_sym  = 2'(s);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      overlap = 1'b1;
      do_reset();

      // reset state
      check("rst state", int'(state_a), 0);
      check("rst out", int'(out_a), 0);
      check("rst count", int'(cnt_a), 0);

      // default pattern 1,0,2,0
      for (int i = 0; i < 4; i++) begin
         feed(sq_def[i]);
         check($sformatf("def state %0d", i), int'(state_a), i + 1);
         check($sformatf("def out %0d", i), int'(out_a), (i == 3) ? 1 : 0);
      end
      check("def count", int'(cnt_a), 1);
      idle();
      check("def pulse width", int'(out_a), 0);

      // pattern 1,0,1,0 overlapping
      do_reset();
      overlap = 1'b1;
      cfg_wr(2, 1);
      for (int i = 0; i < 6; i++) begin
         feed(sq_ovl[i]);
         check($sformatf("ovl state %0d", i), int'(state_a), st_ovl[i]);
         check($sformatf("ovl out %0d", i), int'(out_a), ot_ovl[i]);
      end
      check("ovl count", int'(cnt_a), 2);

      // pattern 1,0,1,0 non-overlapping
      do_reset();
      overlap = 1'b0;
      cfg_wr(2, 1);
      for (int i = 0; i < 6; i++) begin
         feed(sq_ovl[i]);
         check($sformatf("nov state %0d", i), int'(state_a), st_nov[i]);
         check($sformatf("nov out %0d", i), int'(out_a), ot_nov[i]);
      end
      check("nov count", int'(cnt_a), 1);

      // back-to-back overlapping matches with pattern 0,0,0,0 sliced to 0,0 behaviour
      do_reset();
      overlap = 1'b1;
      cfg_wr(0, 0);
      cfg_wr(1, 0);
      cfg_wr(2, 0);
      for (int i = 0; i < 6; i++) begin
         feed(0);
         check($sformatf("b2b out %0d", i), int'(out_a), (i >= 3) ? 1 : 0);
      end
      check("b2b count", int'(cnt_a), 3);

      // idle gap holds the partial match (restored default pattern)
      do_reset();
      overlap = 1'b0;
      feed(1);
      feed(0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check($sformatf("gap state %0d", i), int'(state_a), 2);
         check($sformatf("gap out %0d", i), int'(out_a), 0);
      end
      feed(2);
      check("gap state after 2", int'(state_a), 3);
      feed(0);
      check("gap match", int'(out_a), 1);
      check("gap count", int'(cnt_a), 1);
      feed(1);
      feed(0);
      feed(3);
      check("mismatch state", int'(state_a), 0);
      check("mismatch out", int'(out_a), 0);

      // asynchronous reset mid-sequence
      do_reset();
      overlap = 1'b0;
      feed(1);
      feed(0);
      feed(2);
      check("pre-reset state", int'(state_a), 3);
      init = 1'b0;
      #2;
      check("async rst state", int'(state_a), 0);
      check("async rst out", int'(out_a), 0);
      @(negedge clk);
      init = 1'b1;
      feed(0);
      check("post-rst state", int'(state_a), 0);
      check("post-rst out", int'(out_a), 0);
      for (int i = 0; i < 4; i++) feed(sq_def[i]);
      check("post-rst match", int'(out_a), 1);

      // saturating 2-bit counter, clear wins over a match
      do_reset();
      overlap = 1'b0;
      for (int m = 0; m < 5; m++) begin
         for (int i = 0; i < 4; i++) feed(sq_def[i]);
         check($sformatf("sat count %0d", m), int'(cnt_a), cnt_sat[m]);
      end
      feed(1);
      feed(0);
      feed(2);
      cnt_clr = 1'b1;
      feed(0);
      cnt_clr = 1'b0;
      check("clr match out", int'(out_a), 1);
      check("clr count", int'(cnt_a), 0);

      // pattern write mid-sequence, symbol in the same cycle is dropped
      do_reset();
      overlap = 1'b0;
      feed(1);
      feed(0);
      in_valid = 1'b1;
      in_sym   = 2'd2;
      cfg_we   = 1'b1;
      cfg_idx  = 2'd2;
      cfg_sym  = 2'd3;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      check("cfg clear state", int'(state_a), 0);
      check("cfg clear out", int'(out_a), 0);
      feed(1);
      feed(0);
      feed(3);
      check("newpat state", int'(state_a), 3);
      feed(0);
      check("newpat match", int'(out_a), 1);
      for (int i = 0; i < 4; i++) begin
         feed(sq_def[i]);
         check($sformatf("oldpat out %0d", i), int'(out_a), 0);
      end
      check("oldpat state", int'(state_a), 0);
      check("newpat count", int'(cnt_a), 1);

      // out-of-range pattern index on the DEPTH=3 instance
      do_reset();
      feed_b(1);
      feed_b(0);
      in_valid_b = 1'b0;
      cfg_we_b   = 1'b1;
      cfg_idx_b  = 2'd3;
      cfg_sym_b  = 2'd0;
      @(posedge clk);
      #1;
      cfg_we_b = 1'b0;
      check("oor idx state", int'(state_b), 2);
      feed_b(2);
      check("oor idx match", int'(out_b), 1);
      check("oor idx count", int'(cnt_b), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
